// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two write ports,
// optional same-cycle write bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic w0_ok;
  logic w1_ok;
  logic iss_ok;

  // Register 0 is inert when hardwired: no writes, no issue marks.
  assign w0_ok  = wr0_en && !(ZR && wr0_addr == '0);
  assign w1_ok  = wr1_en && !(ZR && wr1_addr == '0);
  assign iss_ok = iss_en && !(ZR && iss_addr == '0);

  // Clears first, then set, so a new producer supersedes the completing one.
  always_comb begin
    busy_d = busy_q;
    if (w0_ok)  busy_d[wr0_addr] = 1'b0;
    if (w1_ok)  busy_d[wr1_addr] = 1'b0;
    if (iss_ok) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (w0_ok) mem[wr0_addr] <= wr0_data;
      if (w1_ok) mem[wr1_addr] <= wr1_data;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem[addr];
      busy = busy_q[addr];
      if (BP) begin
        if (wr0_en && wr0_addr == addr) begin
          data = wr0_data;
          busy = 1'b0;
        end
        if (wr1_en && wr1_addr == addr) begin
          data = wr1_data;
          busy = 1'b0;
        end
      end
      if (ZR && addr == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default bypassing instance plus a
// 4-read-port, 64-bit, non-bypassing instance.
module tb_regfile_mp;

  logic CLK = 1'b0;
  logic Reset;

  always #5 CLK = ~CLK;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [31:0] busy_vec;

  logic [19:0]  n_rd_addr;
  logic [255:0] n_rd_data;
  logic [3:0]   n_rd_busy;
  logic         n_wr0_en, n_wr1_en, n_iss_en;
  logic [4:0]   n_wr0_addr, n_wr1_addr, n_iss_addr;
  logic [63:0]  n_wr0_data, n_wr1_data;
  logic [31:0]  n_busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_mp u_dut (
    .CLK(CLK), .Reset(Reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  regfile_mp #(
    .DATA_W(64), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(0)
  ) u_nb (
    .CLK(CLK), .Reset(Reset),
    .rd_addr(n_rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
    .wr0_en(n_wr0_en), .wr0_addr(n_wr0_addr), .wr0_data(n_wr0_data),
    .wr1_en(n_wr1_en), .wr1_addr(n_wr1_addr), .wr1_data(n_wr1_data),
    .iss_en(n_iss_en), .iss_addr(n_iss_addr), .busy_vec(n_busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0;
    n_wr0_en = 0; n_wr1_en = 0; n_iss_en = 0;
  endtask

  initial begin
    idle();
    wr0_addr = 0; wr1_addr = 0; iss_addr = 0;
    wr0_data = 0; wr1_data = 0; rd_addr = 0;
    n_wr0_addr = 0; n_wr1_addr = 0; n_iss_addr = 0;
    n_wr0_data = 0; n_wr1_data = 0; n_rd_addr = 0;
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    chk("init_busy", {32'd0, busy_vec}, 64'd0);

    // Populate some state, then reset with a write pending.
    wr0_en = 1; wr0_addr = 1; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 2; wr1_data = 32'h22;
    iss_en = 1; iss_addr = 3;
    tick();
    idle();
    rd_addr = {5'd2, 5'd1};
    #1;
    chk("pre_rst_r1", {32'd0, rd_data[31:0]}, 64'h11);
    chk("pre_rst_r2", {32'd0, rd_data[63:32]}, 64'h22);
    chk("pre_rst_busy3", {63'd0, busy_vec[3]}, 64'd1);

    Reset = 1;
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h44;
    iss_en = 1; iss_addr = 4;
    tick();
    Reset = 0;
    idle();
    rd_addr = {5'd1, 5'd4};
    #1;
    chk("rst_r4", {32'd0, rd_data[31:0]}, 64'd0);
    chk("rst_r1", {32'd0, rd_data[63:32]}, 64'd0);
    chk("rst_busy_vec", {32'd0, busy_vec}, 64'd0);
    chk("rst_rd_busy", {62'd0, rd_busy}, 64'd0);

    // Same-address dual write: wr1 wins, both bypassed and stored.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hAAAA0000;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h5555FFFF;
    rd_addr = {5'd1, 5'd5};
    #1;
    chk("dual_byp", {32'd0, rd_data[31:0]}, 64'h5555FFFF);
    tick();
    idle();
    #1;
    chk("dual_stored", {32'd0, rd_data[31:0]}, 64'h5555FFFF);

    // Issue r7, idle 3 cycles, then write back with bypass.
    iss_en = 1; iss_addr = 7;
    rd_addr = {5'd7, 5'd1};
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy7_idle", {63'd0, busy_vec[7]}, 64'd1);
      chk("rd_busy1_idle", {63'd0, rd_busy[1]}, 64'd1);
      tick();
    end
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h12345678;
    #1;
    chk("wb_rd_busy1", {63'd0, rd_busy[1]}, 64'd0);
    chk("wb_rd_data1", {32'd0, rd_data[63:32]}, 64'h12345678);
    tick();
    idle();
    #1;
    chk("wb_busy7_clr", {63'd0, busy_vec[7]}, 64'd0);
    chk("wb_r7_stored", {32'd0, rd_data[63:32]}, 64'h12345678);

    // Issue and writeback of the same register: set wins.
    iss_en = 1; iss_addr = 9;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h1;
    tick();
    idle();
    rd_addr = {5'd1, 5'd9};
    #1;
    chk("iss_wr_busy9", {63'd0, busy_vec[9]}, 64'd1);
    chk("iss_wr_r9", {32'd0, rd_data[31:0]}, 64'h1);
    chk("iss_wr_rd_busy0", {63'd0, rd_busy[0]}, 64'd1);

    // Register 0 stays zero and never busy.
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 0;
    rd_addr = {5'd1, 5'd0};
    #1;
    chk("r0_wcyc_data", {32'd0, rd_data[31:0]}, 64'd0);
    chk("r0_wcyc_busy", {63'd0, busy_vec[0]}, 64'd0);
    chk("r0_wcyc_rd_busy", {63'd0, rd_busy[0]}, 64'd0);
    tick();
    idle();
    #1;
    chk("r0_after_data", {32'd0, rd_data[31:0]}, 64'd0);
    chk("r0_after_busy", {63'd0, busy_vec[0]}, 64'd0);

    // Non-bypassing 64-bit, 4-port instance.
    n_wr0_en = 1; n_wr0_addr = 3;
    n_wr0_data = 64'hDEADBEEFCAFEF00D;
    n_rd_addr = {4{5'd3}};
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("nb_old", n_rd_data[k*64 +: 64], 64'd0);
    end
    tick();
    idle();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("nb_new", n_rd_data[k*64 +: 64], 64'hDEADBEEFCAFEF00D);
    end

    n_wr0_en = 1; n_wr0_addr = 4; n_wr0_data = 64'hA;
    n_wr1_en = 1; n_wr1_addr = 4; n_wr1_data = 64'hB;
    n_rd_addr = {5'd3, 5'd3, 5'd3, 5'd4};
    tick();
    idle();
    #1;
    chk("nb_wr1_wins", n_rd_data[63:0], 64'hB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the MIPS core, replacing the fixed 32x32 2R/1W file.
- Configurable width, depth and read-port count.
- Two write ports (ALU writeback and load writeback) and optional same-cycle write-to-read bypass.
- Per-register busy scoreboard, set at issue and cleared at writeback, which the hazard unit reads directly.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
CLK  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
rd_addr  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  1 = register on port k has a pending producer
wr0_en  input  1  write port 0 enable (ALU writeback)
wr0_addr  input  ADDR_W  write port 0 address
wr0_data  input  DATA_W  write port 0 data
wr1_en  input  1  write port 1 enable (load writeback)
wr1_addr  input  ADDR_W  write port 1 address
wr1_data  input  DATA_W  write port 1 data
iss_en  input  1  issue: mark iss_addr busy
iss_addr  input  ADDR_W  destination register of issuing instruction
busy_vec  output  2**ADDR_W  registered busy bits, bit i = register i

Behaviour:
Reset:
- On a rising edge with Reset=1, all registers are set to 0 and busy_vec is set to 0.
- Reset overrides wr0, wr1 and iss in the same cycle.
- After reset, rd_data = 0 and rd_busy = 0 for every port.

Write:
- Registered, takes effect at the rising edge.
- If wr0 and wr1 target the same address in the same cycle, wr1 wins.
- With ZERO_REG=1, writes to address 0 are dropped.

Read:
- Combinational from the array, no added latency.
- With BYPASS=1 and a read address matching an enabled write address in the same cycle, rd_data returns that write data (wr1 has priority over wr0).
- With BYPASS=0, rd_data returns the old value until the next cycle.
- With ZERO_REG=1, reads of address 0 return 0 regardless of bypass.

Scoreboard:
- iss_en sets busy[iss_addr] at the edge.
- An enabled write clears busy[wr_addr] at the edge.
- If iss and a write target the same address in the same cycle, the set wins (the new producer supersedes the completing one).
- Two writes to the same address clear the bit once, with no error.
- With ZERO_REG=1, iss to register 0 is ignored and busy[0] stays 0.

rd_busy[k]:
- Normally rd_busy[k] = busy_vec[rd_addr_k].
- With BYPASS=1, rd_busy[k] is forced to 0 when an enabled write to rd_addr_k occurs in the same cycle, because the data is already forwarded.
- With ZERO_REG=1, rd_busy[k] is 0 for address 0.

No internal state machine beyond the array and busy bits. There are no stalls and no backpressure; every input is accepted every cycle.

Test Plan:
- Reset=1 for 1 cycle after random writes -> all rd_data=0, busy_vec=0 on the next cycle; a write issued in the reset cycle is lost.
- wr0 (r5, 0xAAAA0000) and wr1 (r5, 0x5555FFFF) in the same cycle, rd_addr0=5 -> same cycle with BYPASS=1: rd_data0=0x5555FFFF; next cycle: reads 0x5555FFFF.
- iss_en r7, then 3 idle cycles, then wr0 r7=0x12345678 with rd_addr1=7 -> busy_vec[7]=1 for the idle cycles, rd_busy1=0 and rd_data1=0x12345678 in the write cycle, busy_vec[7]=0 after.
- iss_en r9 and wr1 r9=0x1 in the same cycle -> busy_vec[9]=1 after the edge and r9 holds 0x1.
- ZERO_REG=1: wr0 r0=0xFFFFFFFF with iss_en r0 -> rd_data of r0=0 and busy_vec[0]=0 in all cycles, including the write cycle.
- BYPASS=0, NUM_RD=4, DATA_W=64: write r3=0xDEADBEEFCAFEF00D, all 4 ports read r3 -> old value 0 in the write cycle, new value on all 4 ports the following cycle.
